pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Fetch-stage consumer of the execute-stage PCSrc select and branch/jump targets.
- Owns the architectural fetch PC (PCF) and issues one-outstanding fetch requests to instruction memory over a valid/ready request plus valid response interface.
- Drives the IF/ID pipeline register, including a one-entry skid buffer for decode stalls.
- Flushes wrong-path fetches on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value loaded on reset.
- NOP_INSTR, 32'h0000_0013, InstrD value on reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSrcE  in  2  next-PC select: 00 = PC+4, 01 = PCTargetE (branch/JAL), 10 = ALUResultE (JALR), 11 = treated as 00.
- PCTargetE  in  32  PC+imm target from execute.
- ALUResultE  in  32  JALR target from execute.
- StallD  in  1  decode cannot accept a new instruction this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address; always equals PCF.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  instruction returned; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  returned instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID entry valid.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - PCF=RESET_PC, state=FETCH, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, skid buffer empty.
  - A memory response pending at reset is ignored; the memory is reset on the same rst.
- Redirect:
  - redirect = (PCSrcE==01 || PCSrcE==10).
  - target = PCTargetE for 01; {ALUResultE[31:1],1'b0} for 10.
  - All adds are 32-bit, wrap modulo 2^32; carry discarded.
- States:
  - FETCH: imem_req_valid=1. On req_valid && req_ready, go to WAIT.
  - WAIT: imem_req_valid=0. On rsp_valid:
    - If the IF/ID register is free (ValidD==0 || !StallD): load InstrD=rsp_data, PCD=PCF, PCPlus4D=PCF+4, ValidD=1; PCF<=PCF+4; go to FETCH.
    - Else: capture the response in the skid buffer; PCF<=PCF+4; go to HOLD.
  - HOLD: imem_req_valid=0. When !StallD: move the skid buffer into IF/ID (ValidD=1) and go to FETCH.
  - DROP: imem_req_valid=0. Discard the next rsp_valid; do not update IF/ID; go to FETCH.
- Decode consumption: ValidD clears when !StallD and no new instruction is loaded the same cycle. IF/ID holds all values while StallD=1.
- Redirect priority: redirect beats StallD and beats rsp_valid.
  - PCF<=target; ValidD<=0; InstrD<=NOP_INSTR; skid buffer cleared.
  - From FETCH with no handshake that cycle: stay in FETCH.
  - From FETCH with a handshake that cycle: go to DROP (the accepted request is for the old PC).
  - From WAIT without rsp_valid: go to DROP.
  - From WAIT with rsp_valid: the response is discarded; go to FETCH.
  - From HOLD: go to FETCH.
  - From DROP: stay in DROP unless rsp_valid that cycle, then go to FETCH.
- Latency:
  - Redirect in cycle N puts the target on imem_req_addr at N+1 (from FETCH, WAIT-with-response or HOLD), or in the cycle after the dropped response (from DROP).
  - With ready=1 and response in the next cycle, sustained throughput is 1 instruction per 2 cycles.
- imem_req_addr and imem_req_valid are driven from registered state and PCF only. No combinational path from the E-stage inputs to request outputs.

Test Plan:
- Reset then free-run: ready=1, response 1 cycle after acceptance, StallD=0 -> request addresses 0x0, 0x4, 0x8, 0xC; PCD/InstrD follow in order with ValidD=1.
- Branch redirect in FETCH: PCSrcE=01, PCTargetE=0x100 while idle in FETCH -> next imem_req_addr=0x100; ValidD=0 for one cycle; InstrD=0x00000013.
- JALR alignment: PCSrcE=10, ALUResultE=0x203 -> next fetch address 0x202.
- Redirect while outstanding: redirect to 0x40 in WAIT, response 0xDEADBEEF arrives 2 cycles later -> 0xDEADBEEF never appears in InstrD; next request address=0x40.
- Decode stall with skid: ValidD=1 and StallD=1 when the response for 0x8 arrives -> PCD holds at 0x4 and no new request issues. On StallD=0, PCD=0x8, InstrD=the returned word, then a request for 0xC.
- Async reset mid-WAIT: assert rst between clock edges -> ValidD=0, imem_req_addr=RESET_PC immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory port used by the fetch stage. It carries a valid/ready
// request channel and a valid-only response channel. Only one request is
// outstanding at a time, and exactly one response returns per accepted request.
//
//   req_valid  fetch request valid           (master -> slave)
//   req_addr   fetch address (32 bit)        (master -> slave)
//   req_ready  memory accepts the request    (slave  -> master)
//   rsp_valid  instruction returned          (slave  -> master)
//   rsp_data   returned instruction (32 bit) (slave  -> master)
// -----------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  // The fetch unit issues requests and consumes responses.
  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  // Instruction memory side.
  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Fetch stage. This module owns the architectural fetch PC (PCF) and issues
// fetch requests to instruction memory, with one request outstanding at a time.
// It loads the IF/ID pipeline register and uses a one-entry skid buffer so that
// a response arriving during a decode stall is not lost. Every redirect from
// execute (branch/JAL/JALR) discards wrong-path fetches.
//
// Ports:
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   PCSrcE        next-PC select: 01 = PCTargetE, 10 = ALUResultE (JALR),
//                 00/11 = sequential
//   PCTargetE     branch/JAL target
//   ALUResultE    JALR target; bit 0 is forced to zero
//   StallD        decode cannot accept a new instruction
//   imem          instruction memory port (master side)
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register outputs
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCSrcE,
  input  logic [31:0]     PCTargetE,
  input  logic [31:0]     ALUResultE,
  input  logic            StallD,
  pc_fetch_unit_if.master imem,
  output logic [31:0]     InstrD,
  output logic [31:0]     PCD,
  output logic [31:0]     PCPlus4D,
  output logic            ValidD
);

  // FETCH: request on the bus. WAIT: request accepted, awaiting response.
  // HOLD: response parked in skid buffer during a decode stall.
  // DROP: a wrong-path response is still in flight and must be swallowed.
  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pcf, pcf_n;
  logic [31:0] instr_n, pcd_n, pcplus4_n;
  logic        valid_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
  logic        skid_valid, skid_valid_n;

  logic        handshake;
  logic        redirect;
  logic        load;
  logic [31:0] target;
  logic [31:0] pcf_plus4;

  // The request outputs come only from registered state. This keeps any
  // execute-stage timing path away from the memory interface.
  assign imem.req_valid = (state == ST_FETCH);
  assign imem.req_addr  = pcf;

  assign handshake = (state == ST_FETCH) && imem.req_ready;
  assign redirect  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign target    = (PCSrcE == 2'b10) ? (ALUResultE & 32'hFFFF_FFFE) : PCTargetE;
  assign pcf_plus4 = pcf + 32'd4;

  // Next-state and IF/ID update logic. The normal flow is evaluated first.
  // A redirect then overrides it, because a redirect takes priority over both
  // the stall and any response arriving in the same cycle.
  always_comb begin
    state_n      = state;
    pcf_n        = pcf;
    instr_n      = InstrD;
    pcd_n        = PCD;
    pcplus4_n    = PCPlus4D;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
    skid_valid_n = skid_valid;
    load         = 1'b0;

    case (state)
      ST_FETCH: begin
        if (handshake) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem.rsp_valid) begin
          pcf_n = pcf_plus4;
          if (!ValidD || !StallD) begin
            load      = 1'b1;
            instr_n   = imem.rsp_data;
            pcd_n     = pcf;
            pcplus4_n = pcf_plus4;
            state_n   = ST_FETCH;
          end else begin
            skid_instr_n = imem.rsp_data;
            skid_pc_n    = pcf;
            skid_valid_n = 1'b1;
            state_n      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!StallD) begin
          if (skid_valid) begin
            load      = 1'b1;
            instr_n   = skid_instr;
            pcd_n     = skid_pc;
            pcplus4_n = skid_pc + 32'd4;
          end
          skid_valid_n = 1'b0;
          state_n      = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (imem.rsp_valid) state_n = ST_FETCH;
      end
    endcase

    // Decode consumes the entry on any unstalled cycle that loads nothing new.
    valid_n = load ? 1'b1 : (StallD ? ValidD : 1'b0);

    if (redirect) begin
      pcf_n        = target;
      valid_n      = 1'b0;
      instr_n      = NOP_INSTR;
      skid_valid_n = 1'b0;
      // If a request for the old PC was accepted and its response has not
      // arrived yet, that response must be swallowed in DROP.
      case (state)
        ST_FETCH: state_n = handshake ? ST_DROP : ST_FETCH;
        ST_WAIT:  state_n = imem.rsp_valid ? ST_FETCH : ST_DROP;
        ST_HOLD:  state_n = ST_FETCH;
        ST_DROP:  state_n = imem.rsp_valid ? ST_FETCH : ST_DROP;
      endcase
    end
  end

  // State, PC, IF/ID and skid registers. The reset is asynchronous, so a
  // mid-transaction reset takes effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      pcf        <= RESET_PC;
      InstrD     <= NOP_INSTR;
      PCD        <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      skid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      InstrD     <= instr_n;
      PCD        <= pcd_n;
      PCPlus4D   <= pcplus4_n;
      ValidD     <= valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
      skid_valid <= skid_valid_n;
    end
  end

endmodule
